// File: rtl/uart_tx_sched_pkg.sv
// Shared encodings and payload types for the UART transmit scheduler.
package uart_tx_sched_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned WORD_W = 16;
    localparam int unsigned ST_W   = 2;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_LOAD    = 2'd1;
    localparam logic [1:0] ST_WAIT_HI = 2'd2;
    localparam logic [1:0] ST_WAIT_LO = 2'd3;

    // Everything frozen at grant time for the life of one transaction.
    typedef struct packed {
        logic [WORD_W-1:0] word;
        logic              two;
        logic              par_en;
        logic              par_typ;
    } txn_t;

    // Byte 0 lives in the low half of the word, byte 1 in the high half.
    function automatic logic [BYTE_W-1:0] pick_byte(input logic [WORD_W-1:0] word,
                                                    input logic              idx);
        return idx ? word[WORD_W-1:BYTE_W] : word[BYTE_W-1:0];
    endfunction

endpackage

// File: rtl/uart_tx_sched_rr_arbiter.sv
// Round-robin arbiter: first set request strictly after the pointer, wrapping.
module rr_arbiter #(
    parameter  int unsigned NUM_REQ = 2,
    localparam int unsigned PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [PTR_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] gnt_c_o,
    output logic [PTR_W-1:0]   idx_c_o,
    output logic               any_c_o
);

    logic [PTR_W-1:0] cand;
    logic             found;

    // Scan candidates ptr+1, ptr+2, ... ptr+NUM_REQ and keep the first hit.
    always_comb begin
        gnt_c_o = '0;
        idx_c_o = ptr_i;
        cand    = '0;
        found   = 1'b0;
        for (int k = 1; k <= int'(NUM_REQ); k++) begin
            cand = PTR_W'((int'(ptr_i) + k) % int'(NUM_REQ));
            if (!found && req_i[cand]) begin
                gnt_c_o[cand] = 1'b1;
                idx_c_o       = cand;
                found         = 1'b1;
            end
        end
        any_c_o = found;
    end

endmodule

// File: rtl/uart_tx_sched.sv
// Sequences 1- or 2-byte requests from several clients into a UART transmitter.
module uart_tx_sched
    import uart_tx_sched_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned BUSY_TO = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [WORD_W*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]        req_two,
    input  logic                      cfg_par_en,
    input  logic                      cfg_par_typ,
    input  logic                      tx_busy,
    output logic [BYTE_W-1:0]         tx_p_data,
    output logic                      tx_data_valid,
    output logic                      tx_par_en,
    output logic                      tx_par_typ,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        done,
    output logic                      err_timeout,
    output logic                      sched_busy
);

    localparam int unsigned PTR_W = $clog2(NUM_REQ);
    localparam int unsigned CNT_W = $clog2(BUSY_TO + 1);

    logic [ST_W-1:0]    state_q,  state_d;
    logic [PTR_W-1:0]   ptr_q,    ptr_d;
    logic [PTR_W-1:0]   owner_q,  owner_d;
    txn_t               txn_q,    txn_d;
    logic               bidx_q,   bidx_d;
    logic [CNT_W-1:0]   cnt_q,    cnt_d;
    logic [BYTE_W-1:0]  p_data_q, p_data_d;
    logic               dv_q,     dv_d;
    logic [NUM_REQ-1:0] gnt_q,    gnt_d;
    logic [NUM_REQ-1:0] done_q,   done_d;
    logic               err_q,    err_d;
    logic               sb_q,     sb_d;

    logic [NUM_REQ-1:0] arb_gnt_c;
    logic [PTR_W-1:0]   arb_idx_c;
    logic               arb_any_c;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req_i   (req),
        .ptr_i   (ptr_q),
        .gnt_c_o (arb_gnt_c),
        .idx_c_o (arb_idx_c),
        .any_c_o (arb_any_c)
    );

    // Next-state and registered-output logic for the transfer sequencer.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        owner_d  = owner_q;
        txn_d    = txn_q;
        bidx_d   = bidx_q;
        cnt_d    = cnt_q;
        p_data_d = p_data_q;
        dv_d     = 1'b0;
        gnt_d    = '0;
        done_d   = '0;
        err_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (arb_any_c) begin
                    ptr_d         = arb_idx_c;
                    owner_d       = arb_idx_c;
                    txn_d.word    = WORD_W'(req_data >> (WORD_W * arb_idx_c));
                    txn_d.two     = req_two[arb_idx_c];
                    txn_d.par_en  = cfg_par_en;
                    txn_d.par_typ = cfg_par_typ;
                    bidx_d        = 1'b0;
                    gnt_d         = arb_gnt_c;
                    state_d       = ST_LOAD;
                end
            end
            ST_LOAD: begin
                // Never strobe a byte into a transmitter that is still framing.
                if (!tx_busy) begin
                    p_data_d = pick_byte(txn_q.word, bidx_q);
                    dv_d     = 1'b1;
                    cnt_d    = '0;
                    state_d  = ST_WAIT_HI;
                end
            end
            ST_WAIT_HI: begin
                if (tx_busy) begin
                    state_d = ST_WAIT_LO;
                end else if (cnt_q == CNT_W'(BUSY_TO - 1)) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_WAIT_LO: begin
                if (!tx_busy) begin
                    if (!bidx_q && txn_q.two) begin
                        bidx_d  = 1'b1;
                        state_d = ST_LOAD;
                    end else begin
                        done_d  = NUM_REQ'(1) << owner_q;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        sb_d = (state_d != ST_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            ptr_q    <= PTR_W'(NUM_REQ - 1);
            owner_q  <= '0;
            txn_q    <= '0;
            bidx_q   <= 1'b0;
            cnt_q    <= '0;
            p_data_q <= '0;
            dv_q     <= 1'b0;
            gnt_q    <= '0;
            done_q   <= '0;
            err_q    <= 1'b0;
            sb_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            owner_q  <= owner_d;
            txn_q    <= txn_d;
            bidx_q   <= bidx_d;
            cnt_q    <= cnt_d;
            p_data_q <= p_data_d;
            dv_q     <= dv_d;
            gnt_q    <= gnt_d;
            done_q   <= done_d;
            err_q    <= err_d;
            sb_q     <= sb_d;
        end
    end

    assign tx_p_data     = p_data_q;
    assign tx_data_valid = dv_q;
    assign tx_par_en     = txn_q.par_en;
    assign tx_par_typ    = txn_q.par_typ;
    assign gnt           = gnt_q;
    assign done          = done_q;
    assign err_timeout   = err_q;
    assign sched_busy    = sb_q;

endmodule
